// File: rtl/addr_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package addr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } addr_state_t;

  function automatic int unsigned ndig(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  function automatic bit params_legal(input int unsigned width, input int unsigned digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/addr_digit_u.sv
// Combinational DIGIT-bit ripple adder used for one digit step of the serial adder.
module addr_digit_u #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  logic [DIGIT:0] w_c;

  always_comb begin
    w_c    = '0;
    s      = '0;
    w_c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]     = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
    cout = w_c[DIGIT];
  end

endmodule

// File: rtl/addr_serial_u.sv
// Digit-serial unsigned adder with valid/ready on both sides.
// Define ADDR_SERIAL_DMR_EN to add a duplicated digit adder that raises a sticky fault flag.
module addr_serial_u
  import addr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy,
  output logic             fault
);

  localparam int unsigned NDIG = ndig(WIDTH, DIGIT);
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (!params_legal(WIDTH, DIGIT)) begin : g_bad_params
    $error("addr_serial_u: WIDTH must be a positive multiple of DIGIT");
  end

  addr_state_t        r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH:0]     r_sum;
  logic               r_carry;
  logic [CW-1:0]      r_cnt;

  logic [DIGIT-1:0]       w_s;
  logic                   w_cout;
  logic [WIDTH+DIGIT-1:0] w_sum_cat;
  logic                   w_last;

  addr_digit_u #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a   (r_a[DIGIT-1:0]),
    .b   (r_b[DIGIT-1:0]),
    .cin (r_carry),
    .s   (w_s),
    .cout(w_cout)
  );

  // New digit enters at the top; after NDIG steps digit 0 sits at bit 0.
  assign w_sum_cat = {w_s, r_sum[WIDTH-1:0]};
  assign w_last    = (r_cnt == CW'(NDIG - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a              <= r_a >> DIGIT;
          r_b              <= r_b >> DIGIT;
          r_sum[WIDTH-1:0] <= w_sum_cat[WIDTH+DIGIT-1:DIGIT];
          r_carry          <= w_cout;
          r_cnt            <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum[WIDTH] <= w_cout;
            r_state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ADDR_SERIAL_DMR_EN
  logic [DIGIT-1:0] w_s_dup;
  logic             w_cout_dup;
  logic             r_fault;

  addr_digit_u #(
    .DIGIT(DIGIT)
  ) u_digit_dup (
    .a   (r_a[DIGIT-1:0]),
    .b   (r_b[DIGIT-1:0]),
    .cin (r_carry),
    .s   (w_s_dup),
    .cout(w_cout_dup)
  );

  // Sticky until the next accept; the primary copy's result is always used.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault <= 1'b0;
    end else if (r_state == ST_IDLE && in_valid) begin
      r_fault <= 1'b0;
    end else if (r_state == ST_RUN && ({w_cout, w_s} != {w_cout_dup, w_s_dup})) begin
      r_fault <= 1'b1;
    end
  end

  assign fault = r_fault;
`else
  assign fault = 1'b0;
`endif

  assign in_ready  = (r_state == ST_IDLE) && !rst;
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign sum       = r_sum;

endmodule

// File: tb/tb_addr_serial_u.sv
// Directed self-checking bench for addr_serial_u across several WIDTH/DIGIT builds.
module tb_addr_serial_u;

  localparam int NI = 6;

  function automatic int w_of(input int k);
    case (k)
      1, 2:    return 16;
      default: return 8;
    endcase
  endfunction

  function automatic int d_of(input int k);
    case (k)
      0:       return 2;
      1:       return 4;
      2:       return 1;
      3:       return 1;
      4:       return 4;
      default: return 8;
    endcase
  endfunction

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NI-1:0] in_valid = '0;
  logic [NI-1:0] out_ready = '0;
  logic [NI-1:0] in_ready, out_valid, busy, fault;
  logic [15:0]   a_v [NI];
  logic [15:0]   b_v [NI];
  logic [16:0]   sum_v [NI];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int WL = w_of(g);
    localparam int DL = d_of(g);
    logic [WL:0] s;
    addr_serial_u #(
      .WIDTH(WL),
      .DIGIT(DL)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .a        (a_v[g][WL-1:0]),
      .b        (b_v[g][WL-1:0]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .sum      (s),
      .busy     (busy[g]),
      .fault    (fault[g])
    );
    assign sum_v[g] = 17'(s);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transaction on instance k; bp>0 holds out_ready low that many cycles in DONE.
  task automatic do_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                       input int bp, input bit pulse);
    logic [15:0] mask, am, bm;
    logic [16:0] exp;
    int          nd, n;
    mask = 16'((32'h1 << w_of(k)) - 1);
    am   = av & mask;
    bm   = bv & mask;
    exp  = 17'(am) + 17'(bm);
    nd   = w_of(k) / d_of(k);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready[k]), 32'd1);
    a_v[k]       = am;
    b_v[k]       = bm;
    in_valid[k]  = 1'b1;
    out_ready[k] = (bp == 0);
    @(negedge clk);
    in_valid[k] = 1'b0;
    a_v[k]      = ~am;
    b_v[k]      = 16'h5a5a;
    check("busy_run", 32'(busy[k]), 32'd1);
    check("in_ready_run", 32'(in_ready[k]), 32'd0);
    n = 0;
    while (!out_valid[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(nd));
    check("sum", 32'(sum_v[k]), 32'(exp));
    check("fault_clean", 32'(fault[k]), 32'd0);
    if (bp > 0) begin
      for (int i = 0; i < bp; i++) begin
        if (pulse && i == 2) begin
          a_v[k]      = 16'h0033;
          b_v[k]      = 16'h0044;
          in_valid[k] = 1'b1;
        end
        @(negedge clk);
        in_valid[k] = 1'b0;
        check("hold_valid", 32'(out_valid[k]), 32'd1);
        check("hold_sum", 32'(sum_v[k]), 32'(exp));
        check("hold_fault", 32'(fault[k]), 32'd0);
      end
      check("hold_in_ready", 32'(in_ready[k]), 32'd0);
      out_ready[k] = 1'b1;
    end
    @(negedge clk);
    check("ret_out_valid", 32'(out_valid[k]), 32'd0);
    check("ret_in_ready", 32'(in_ready[k]), 32'd1);
    check("ret_busy", 32'(busy[k]), 32'd0);
    out_ready[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      a_v[k] = '0;
      b_v[k] = '0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("rst_in_ready", 32'(in_ready[k]), 32'd0);
      check("rst_out_valid", 32'(out_valid[k]), 32'd0);
      check("rst_busy", 32'(busy[k]), 32'd0);
      check("rst_sum", 32'(sum_v[k]), 32'd0);
      check("rst_fault", 32'(fault[k]), 32'd0);
    end
    rst = 1'b0;
    #1 check("post_rst_in_ready", 32'(in_ready[0]), 32'd1);

    // Directed vectors from the test plan.
    do_op(0, 16'h00ff, 16'h0001, 0, 1'b0);     // 0x100, 4 cycles
    do_op(1, 16'habcd, 16'h1234, 0, 1'b0);     // 0x0BE01, 4 cycles
    do_op(2, 16'habcd, 16'h1234, 0, 1'b0);     // 0x0BE01, 16 cycles
    do_op(1, 16'hffff, 16'hffff, 0, 1'b0);     // 0x1FFFE
    do_op(0, 16'h00a5, 16'h005a, 10, 1'b1);    // backpressure plus ignored pulse
    do_op(5, 16'h00ff, 16'h00ff, 0, 1'b0);     // DIGIT=WIDTH
    do_op(3, 16'h0000, 16'h0000, 1, 1'b0);

    // Reset in the middle of RUN on the 8/2 instance.
    @(negedge clk);
    a_v[0]      = 16'h00ff;
    b_v[0]      = 16'h00ff;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready[0]), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
    check("mid_rst_busy", 32'(busy[0]), 32'd0);
    check("mid_rst_sum", 32'(sum_v[0]), 32'd0);
    check("mid_rst_in_ready1", 32'(in_ready[0]), 32'd1);
    do_op(0, 16'h0080, 16'h0080, 0, 1'b0);

`ifdef ADDR_SERIAL_DMR_EN
    // Corrupt the duplicate's carry for exactly one RUN cycle.
    @(negedge clk);
    a_v[0]      = 16'h0001;
    b_v[0]      = 16'h0001;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    force g_dut[0].u_dut.u_digit_dup.cout = 1'b1;
    @(negedge clk);
    release g_dut[0].u_dut.u_digit_dup.cout;
    begin
      int n;
      n = 0;
      while (!out_valid[0] && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    check("dmr_valid", 32'(out_valid[0]), 32'd1);
    check("dmr_fault", 32'(fault[0]), 32'd1);
    check("dmr_sum", 32'(sum_v[0]), 32'h002);
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    do_op(0, 16'h0011, 16'h0022, 0, 1'b0);
`endif

    // Grid sweep of 8-bit operands on each DIGIT, with random backpressure.
    for (int ii = 0; ii < 4; ii++) begin
      int k;
      k = (ii == 0) ? 3 : (ii == 1) ? 0 : (ii == 2) ? 4 : 5;
      for (int x = 0; x < 256; x += 51) begin
        for (int y = 0; y < 256; y += 37) begin
          do_op(k, 16'(x), 16'(y), int'($urandom_range(0, 2)), 1'b0);
        end
      end
      do_op(k, 16'h00ff, 16'h00ff, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addr_serial_u.md
# addr_serial_u

Parametrised, digit-serial unsigned adder with a valid/ready handshake on both sides. It generalises the fixed 8-bit combinational adder family to any width. Each cycle it processes DIGIT bits, trading latency for a small adder cone and a small fault cross-section. It sits between operand producers and result consumers in the fault-resilient arithmetic datapath. An optional duplicated digit adder flags transient mismatches.

## Interface
Parameters:
- WIDTH, 8: operand width in bits; must be a multiple of DIGIT and ≥ DIGIT.
- DIGIT, 2: bits added per cycle; 1 ≤ DIGIT ≤ WIDTH.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a/b are valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- out_valid  out  1  sum is valid.
- out_ready  in  1  consumer takes the sum this cycle.
- sum  out  WIDTH+1  a+b; the MSB is the carry out.
- busy  out  1  an operation is in progress, from accept until the result is taken.
- fault  out  1  DMR mismatch seen during this operation; tied 0 when DMR is compiled out.

## Operation
- States: IDLE, RUN, DONE. NDIG = WIDTH/DIGIT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a and b into shift registers, clear the carry, digit counter and fault, go to RUN.
- RUN:
  - Each cycle, add the low DIGIT bits of the A and B shift registers plus the carry register.
  - Shift the DIGIT-bit result into the top of the sum shift register, shift A and B right by DIGIT, and register the carry out.
  - The counter increments. When counter==NDIG-1, go to DONE; sum[WIDTH] takes the final carry.
- DONE:
  - out_valid=1; sum and fault are held stable.
  - On out_ready, return to IDLE.
- in_ready=0 in RUN and DONE. in_valid asserted there is ignored and not queued.
- The result is exact modulo 2^(WIDTH+1); there is no overflow condition.
- Reset from any state: state=IDLE; sum, counter, carry and fault are zeroed; an in-flight operation is discarded with no output.
- Reset values: in_ready=0 while rst is high and 1 from the first cycle after; out_valid=0, busy=0, sum=0, fault=0.
- a and b may change freely after acceptance; only the latched copies are used.

## Timing
- Accept on edge E0. RUN occupies edges E1..E_NDIG. out_valid is high from E_NDIG.
- Latency is NDIG cycles from accept to out_valid.
- With out_ready held high, the block returns to IDLE at E_NDIG+1. Peak throughput is one result per NDIG+2 cycles.
- out_valid without out_ready: hold indefinitely, with no change to sum or fault.
- Special cases:
  - DIGIT=WIDTH gives NDIG=1, a single RUN cycle.
  - DIGIT=1 gives a bit-serial adder.
- The critical path is one DIGIT-bit ripple plus a register. It is independent of WIDTH.

## Configuration
- ADDR_SERIAL_DMR_EN defined:
  - A second addr_digit_u computes the same digit every RUN cycle.
  - Any mismatch in sum bits or carry sets fault, which is sticky until the next accept or reset.
  - The primary copy's result is always the one used.
- Undefined: a single adder instance; fault is constant 0.

## Structure
- Package addr_pkg:
  - addr_state_t enum (IDLE, RUN, DONE).
  - Function ndig(WIDTH, DIGIT).
  - Elaboration-time parameter legality checks (WIDTH % DIGIT == 0).
- Sub-module addr_digit_u:
  - Combinational DIGIT-bit ripple adder; ports a, b, cin, s, cout.
  - Instanced once, or twice under ADDR_SERIAL_DMR_EN.
- Top level: FSM, counter of $clog2(NDIG) bits (minimum 1), the A/B/sum shift registers, and the carry register.

## Test plan
- WIDTH=8, DIGIT=2, a=0xFF, b=0x01, out_ready=1 → out_valid rises 4 cycles after accept with sum=0x100 and fault=0; in_ready returns next cycle.
- WIDTH=16, DIGIT=4, a=0xABCD, b=0x1234 → sum=0x0BE01 after 4 cycles; the same operands with DIGIT=1 give the same sum after 16 cycles.
- Backpressure: out_ready=0 for 10 cycles after out_valid → sum, fault and out_valid are held. A second in_valid pulse during this time is not accepted.
- Reset mid-RUN (cycle 2 of 4) → the next cycle shows out_valid=0, busy=0, sum=0, in_ready=1. A fresh 0x80+0x80 then gives 0x100.
- DMR build, force the duplicate's cout=1 for one RUN cycle → fault=1 at DONE with the correct sum. The next clean operation gives fault=0.
- Exhaustive 8-bit sweep, DIGIT∈{1,2,4,8}, random out_ready → every sum equals a+b.
